// File: rtl/ssd_scan_ctl_pkg.sv
// Shared constants for the seven-segment scan controller:
// anode patterns, FSM encoding and digit count.
package ssd_scan_ctl_pkg;

  localparam int N_DIG = 4;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Index k selects the active-low one-hot anode for digit k.
  localparam logic [N_DIG-1:0][3:0] AN_SEL = {
    4'b0111,
    4'b1011,
    4'b1101,
    4'b1110
  };

  localparam logic [0:0] ST_GAP  = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

endpackage

// File: rtl/ssd_tick_gen.sv
// Free-running prescaler; tick pulses for one enabled
// cycle every 2^DIV_BITS enabled cycles.
module ssd_tick_gen #(
  parameter int DIV_BITS = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  logic [DIV_BITS-1:0] cnt;

  assign tick = en & (&cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan_ctl.sv
// 4-digit common-anode scan controller with blank gap,
// leading-zero suppression and per-frame input snapshot.
module ssd_scan_ctl
  import ssd_scan_ctl_pkg::*;
#(
  parameter int DIV_BITS = 17,
  parameter int GAP_CYC  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic        blank_lz,
  output logic [3:0]  scan_digit,
  output logic        dp_n,
  output logic [3:0]  ssd_an,
  output logic [1:0]  scan_idx
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  logic          tick;
  logic [0:0]    state;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    idx;
  logic          loaded;
  logic [15:0]   snap_d;
  logic [3:0]    snap_dp;
  logic          snap_lz;
  logic [3:0]    blank;
  logic          gap_done;
  logic          load;
  logic          lit;
  logic [3:0]    cur_digit;

  ssd_tick_gen #(
    .DIV_BITS(DIV_BITS)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick)
  );

  assign gap_done = (GAP_CYC == 0) || (gap_cnt == GAP_LAST);
  assign load = en & (~loaded | (tick & (idx == 2'd3)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_GAP;
      gap_cnt <= '0;
      idx     <= 2'd0;
      loaded  <= 1'b0;
      snap_d  <= '0;
      snap_dp <= '0;
      snap_lz <= 1'b0;
    end else begin
      if (load) begin
        snap_d  <= digits;
        snap_dp <= dp_en;
        snap_lz <= blank_lz;
      end
      if (en) begin
        loaded <= 1'b1;
      end
      // Pausing parks the FSM at a fresh gap for this digit.
      if (!en) begin
        state   <= ST_GAP;
        gap_cnt <= '0;
      end else if (tick) begin
        idx     <= idx + 2'd1;
        state   <= ST_GAP;
        gap_cnt <= '0;
      end else if (state == ST_GAP) begin
        if (gap_done) begin
          state <= ST_SHOW;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    blank = '0;
    if (snap_lz) begin
      blank[3] = (snap_d[15:12] == 4'h0);
      blank[2] = (snap_d[15:8] == 8'h00);
      blank[1] = (snap_d[15:4] == 12'h000);
    end
  end

  assign lit = en & (state == ST_SHOW) & ~blank[idx];
  assign cur_digit = snap_d[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssd_an     <= AN_OFF;
      dp_n       <= 1'b1;
      scan_digit <= 4'h0;
      scan_idx   <= 2'd0;
    end else begin
      ssd_an     <= lit ? AN_SEL[idx] : AN_OFF;
      dp_n       <= ~(lit & snap_dp[idx]);
      scan_digit <= cur_digit;
      scan_idx   <= idx;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Randomised bench for ssd_scan_ctl: two builds
// (gap 2 and gap 0) against a slot-level reference model.
module tb_ssd_scan_ctl;

  localparam int SLOT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic        blank_lz;

  logic [3:0] dig0, an0, dig1, an1;
  logic       dpn0, dpn1;
  logic [1:0] idx0, idx1;

  int n_vec = 0;
  int n_err = 0;

  // reference model: slot index, position, cycles since gap start
  int          m_idx, m_pos, m_since;
  logic [15:0] m_d;
  logic [3:0]  m_dp;
  logic        m_lz, m_loaded;

  always #5 clk = ~clk;

  ssd_scan_ctl #(.DIV_BITS(3), .GAP_CYC(2)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .digits(digits), .dp_en(dp_en),
    .blank_lz(blank_lz),
    .scan_digit(dig0), .dp_n(dpn0),
    .ssd_an(an0), .scan_idx(idx0)
  );

  ssd_scan_ctl #(.DIV_BITS(3), .GAP_CYC(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .digits(digits), .dp_en(dp_en),
    .blank_lz(blank_lz),
    .scan_digit(dig1), .dp_n(dpn1),
    .ssd_an(an1), .scan_idx(idx1)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_blank(input int k);
    return m_lz && (k > 0) && ((m_d >> (4 * k)) == 16'h0);
  endfunction

  task automatic m_reset();
    m_idx = 0; m_pos = 0; m_since = 0;
    m_d = '0; m_dp = '0; m_lz = 1'b0;
    m_loaded = 1'b0;
  endtask

  task automatic step();
    logic [3:0] ea0, ea1, edg;
    logic       ed0, ed1, lit0, lit1;
    logic [1:0] ei;
    lit0 = en && (m_since >= 2) && !m_blank(m_idx);
    lit1 = en && (m_since >= 1) && !m_blank(m_idx);
    ea0 = lit0 ? ~(4'b0001 << m_idx) : 4'hF;
    ea1 = lit1 ? ~(4'b0001 << m_idx) : 4'hF;
    ed0 = !(lit0 && m_dp[m_idx]);
    ed1 = !(lit1 && m_dp[m_idx]);
    edg = m_d[4*m_idx +: 4];
    ei  = 2'(m_idx);
    if (en) begin
      if (!m_loaded || (m_pos == SLOT - 1 && m_idx == 3)) begin
        m_d = digits; m_dp = dp_en; m_lz = blank_lz;
      end
      m_loaded = 1'b1;
      if (m_pos == SLOT - 1) begin
        m_pos = 0; m_since = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_pos++;
        if (m_since < 100) m_since++;
      end
    end else begin
      m_since = 0;
    end
    @(posedge clk);
    #1;
    chk("an_g2", 16'(an0), 16'(ea0));
    chk("dp_g2", 16'(dpn0), 16'(ed0));
    chk("dig_g2", 16'(dig0), 16'(edg));
    chk("idx_g2", 16'(idx0), 16'(ei));
    chk("an_g0", 16'(an1), 16'(ea1));
    chk("dp_g0", 16'(dpn1), 16'(ed1));
    chk("dig_g0", 16'(dig1), 16'(edg));
    chk("idx_g0", 16'(idx1), 16'(ei));
    chk("multi_an_g0", 16'($countones(~an1) > 1), 16'h0);
  endtask

  task automatic run(input int n, input logic [15:0] d,
                     input logic [3:0] dp, input logic lz,
                     input logic e);
    digits = d; dp_en = dp; blank_lz = lz; en = e;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_an_g2", 16'(an0), 16'hF);
    chk("rst_idx_g2", 16'(idx0), 16'h0);
    chk("rst_dp_g2", 16'(dpn0), 16'h1);
    chk("rst_an_g0", 16'(an1), 16'hF);
    chk("rst_idx_g0", 16'(idx1), 16'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_run(input int n);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = 16'($urandom);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(1, 0) == 0) d[4*k +: 4] = 4'h0;
      digits   = d;
      dp_en    = 4'($urandom);
      blank_lz = 1'($urandom);
      en       = ($urandom_range(15, 0) != 0);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    digits = '0; dp_en = '0; blank_lz = 1'b0;
    m_reset();
    #12;
    chk("init_an", 16'(an0), 16'hF);
    chk("init_dig", 16'(dig0), 16'h0);
    chk("init_dp", 16'(dpn0), 16'h1);
    chk("init_idx", 16'(idx0), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(40, 16'h1234, 4'b0000, 1'b0, 1'b1);
    run(14, 16'hABCD, 4'b0000, 1'b0, 1'b1);
    run(34, 16'h0050, 4'b0000, 1'b1, 1'b1);
    run(32, 16'h0000, 4'b0000, 1'b1, 1'b1);
    run(32, 16'h1234, 4'b0100, 1'b0, 1'b1);
    run(32, 16'h0012, 4'b0100, 1'b1, 1'b1);
    run(11, 16'h1234, 4'b0000, 1'b0, 1'b1);
    run(5, 16'h1234, 4'b0000, 1'b0, 1'b0);
    run(20, 16'h1234, 4'b0000, 1'b0, 1'b1);
    mid_reset();
    rand_run(1500);
    mid_reset();
    rand_run(800);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
